// File: rtl/apb_uart_regs.sv
// APB register bank for the UART: TX/RX byte FIFOs, status, control, baud divisor and interrupt.
module apb_uart_regs #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RST   = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] baud_div,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [2:0] A_TXDATA = 3'd0;
  localparam logic [2:0] A_RXDATA = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;
  localparam logic [2:0] A_BAUD   = 3'd4;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    tx_mem_d [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_d [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [15:0]   baud_q, baud_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic          irq_q, irq_d;

  logic [2:0] addr;
  logic       acc, wr_acc, rd_acc;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push_req, tx_push, tx_pop;
  logic       rx_push_req, rx_push, rx_pop;
  logic [5:0] status;
  logic       unused_ok;

  assign addr   = paddr[4:2];
  assign acc    = psel & penable;
  assign wr_acc = acc & pwrite;
  assign rd_acc = acc & ~pwrite;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

  assign tx_valid    = ~tx_empty & ctrl_q[0];
  assign tx_data     = tx_mem_q[tx_rd_q[AW-1:0]];
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr_acc & (addr == A_TXDATA);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  assign rx_pop      = rd_acc & (addr == A_RXDATA) & ~rx_empty;
  assign rx_push_req = rx_valid & ctrl_q[1];
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);

  assign status   = {rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
  assign pready   = 1'b1;
  assign baud_div = baud_q;
  assign irq      = irq_q;

  assign unused_ok = ^{paddr[31:5], paddr[1:0], pwdata[31:16]};

  // Read mux of the addressed register; zero when not selected.
  always_comb begin
    prdata = 32'd0;
    if (psel) begin
      case (addr)
        A_RXDATA: if (!rx_empty) prdata = {24'd0, rx_mem_q[rx_rd_q[AW-1:0]]};
        A_STATUS: prdata = {26'd0, status};
        A_CTRL:   prdata = {28'd0, ctrl_q};
        A_BAUD:   prdata = {16'd0, baud_q};
        default:  prdata = 32'd0;
      endcase
    end
  end

  // Next-state for FIFOs, registers, sticky overflow flags and interrupt.
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;

    if (tx_push) begin
      tx_mem_d[tx_wr_q[AW-1:0]] = pwdata[7:0];
      tx_wr_d = tx_wr_q + PW'(1);
    end
    if (tx_pop) tx_rd_d = tx_rd_q + PW'(1);

    if (rx_push) begin
      rx_mem_d[rx_wr_q[AW-1:0]] = rx_data;
      rx_wr_d = rx_wr_q + PW'(1);
    end
    if (rx_pop) rx_rd_d = rx_rd_q + PW'(1);

    if (wr_acc && addr == A_CTRL) ctrl_d = pwdata[3:0];
    if (wr_acc && addr == A_BAUD) baud_d = pwdata[15:0];

    // Clear first so a same-cycle hardware overflow wins.
    if (wr_acc && addr == A_STATUS) begin
      if (pwdata[4]) tx_ovf_d = 1'b0;
      if (pwdata[5]) rx_ovf_d = 1'b0;
    end
    if (tx_push_req && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_push_req && rx_full && !rx_pop) rx_ovf_d = 1'b1;

    irq_d = (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty) | tx_ovf_q | rx_ovf_q;
  end

  // State registers with synchronous reset taking priority over all updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= 8'd0;
        rx_mem_q[i] <= 8'd0;
      end
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      ctrl_q   <= 4'd0;
      baud_q   <= BAUD_RST;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      ctrl_q   <= ctrl_d;
      baud_q   <= baud_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_regs.sv
// Bench for apb_uart_regs: directed scenarios then random traffic against a queue-based model.
module tb_apb_uart_regs;

  localparam int DEPTH = 8;

  logic        clk, rst;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, irq;
  logic [15:0] baud_div;

  apb_uart_regs dut (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .baud_div(baud_div), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit rand_side = 0;
  logic [31:0] last_prdata;

  // Reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [3:0]  ctrl_m = 4'd0;
  logic [15:0] baud_m = 16'd434;
  bit          txo_m = 0, rxo_m = 0, irq_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_m();
    status_m = {26'd0, rxo_m, txo_m, rx_q.size() == DEPTH, rx_q.size() == 0,
                tx_q.size() == DEPTH, tx_q.size() == 0};
  endfunction

  function automatic logic [31:0] exp_prdata();
    if (!psel) return 32'd0;
    case (int'(paddr[4:2]))
      1: return (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
      2: return status_m();
      3: return {28'd0, ctrl_m};
      4: return {16'd0, baud_m};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    bit acc, tx_pop, rx_pop, tx_full0, rx_full0, irq_n;
    int a;
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      ctrl_m = 4'd0; baud_m = 16'd434; txo_m = 0; rxo_m = 0; irq_m = 0;
      return;
    end
    irq_n = (ctrl_m[2] && rx_q.size() != 0) || (ctrl_m[3] && tx_q.size() == 0) || txo_m || rxo_m;
    acc = psel && penable;
    a = int'(paddr[4:2]);
    tx_full0 = (tx_q.size() == DEPTH);
    rx_full0 = (rx_q.size() == DEPTH);
    tx_pop = ctrl_m[0] && tx_q.size() != 0 && tx_ready;
    rx_pop = acc && !pwrite && a == 1 && rx_q.size() != 0;
    if (acc && pwrite && a == 2) begin
      if (pwdata[4]) txo_m = 0;
      if (pwdata[5]) rxo_m = 0;
    end
    if (tx_pop) void'(tx_q.pop_front());
    if (acc && pwrite && a == 0) begin
      if (!tx_full0 || tx_pop) tx_q.push_back(pwdata[7:0]);
      else txo_m = 1;
    end
    if (rx_pop) void'(rx_q.pop_front());
    if (rx_valid && ctrl_m[1]) begin
      if (!rx_full0 || rx_pop) rx_q.push_back(rx_data);
      else rxo_m = 1;
    end
    if (acc && pwrite && a == 3) ctrl_m = pwdata[3:0];
    if (acc && pwrite && a == 4) baud_m = pwdata[15:0];
    irq_m = irq_n;
  endtask

  // One clock: check read data before the edge, update model, check outputs after it.
  task automatic step();
    bit txv;
    if (rand_side) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    last_prdata = prdata;
    chk("prdata", prdata, exp_prdata());
    model_update();
    @(posedge clk);
    #1;
    txv = ctrl_m[0] && tx_q.size() != 0;
    chk("pready", {31'd0, pready}, 32'd1);
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, txv});
    if (tx_q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, tx_q[0]});
    chk("irq", {31'd0, irq}, {31'd0, irq_m});
    chk("baud_div", {16'd0, baud_div}, {16'd0, baud_m});
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    step();
    penable = 1'b1;
    step();
    d = last_prdata;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b; step(); rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  fill [DEPTH];
    rst = 1'b1; paddr = 32'd0; pwdata = 32'd0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;

    // Reset values
    do_reset(); step();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    apb_read(32'h08, rd); chk("rst_status", rd, 32'h05);
    apb_read(32'h10, rd); chk("rst_baud", rd, 32'd434);
    apb_read(32'h0C, rd); chk("rst_ctrl", rd, 32'h0);

    // TX enable and pop ordering
    apb_write(32'h0C, 32'h1);
    apb_write(32'h00, 32'h41);
    apb_write(32'h00, 32'h42);
    chk("tx_valid_on", {31'd0, tx_valid}, 32'd1);
    chk("tx_head0", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    chk("tx_head1", {24'd0, tx_data}, 32'h42);

    // TX overflow and W1C
    do_reset();
    for (int i = 0; i < 9; i++) apb_write(32'h00, 32'h60 + i);
    apb_read(32'h08, rd); chk("tx_ovf_status", rd, 32'h16);
    apb_write(32'h08, 32'h10);
    apb_read(32'h08, rd); chk("tx_ovf_clr", rd, 32'h06);

    // RX path ordering and empty read
    apb_write(32'h0C, 32'h2);
    rx_pulse(8'hA5); rx_pulse(8'h5A);
    apb_read(32'h04, rd); chk("rx_rd0", rd, 32'hA5);
    apb_read(32'h07, rd); chk("rx_rd1", rd, 32'h5A);
    apb_read(32'h04, rd); chk("rx_rd_empty", rd, 32'h0);
    apb_read(32'h08, rd); chk("rx_empty_bit", {31'd0, rd[2]}, 32'd1);

    // RX full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = 8'($urandom_range(1, 255));
      rx_pulse(fill[i]);
    end
    paddr = 32'h04; pwrite = 1'b0; psel = 1'b1; penable = 1'b0; step();
    penable = 1'b1; rx_valid = 1'b1; rx_data = 8'hC3; step();
    rx_valid = 1'b0; psel = 1'b0; penable = 1'b0;
    chk("rx_full_rd", last_prdata, {24'd0, fill[0]});
    apb_read(32'h08, rd);
    chk("rx_full_kept", {31'd0, rd[3]}, 32'd1);
    chk("rx_ovf_zero", {31'd0, rd[5]}, 32'd0);
    for (int i = 0; i < DEPTH; i++) apb_read(32'h04, rd);
    chk("rx_last_c3", rd, 32'hC3);

    // RX interrupt latency
    apb_write(32'h0C, 32'h6);
    rx_pulse(8'h11);
    chk("irq_lat0", {31'd0, irq}, 32'd0);
    step();
    chk("irq_set", {31'd0, irq}, 32'd1);
    apb_read(32'h04, rd);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    step();
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // Reset during a TXDATA write access
    apb_write(32'h0C, 32'h1);
    paddr = 32'h00; pwdata = 32'h77; pwrite = 1'b1; psel = 1'b1; penable = 1'b0; step();
    penable = 1'b1; rst = 1'b1; step();
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("rst_mid_tx_data", {24'd0, tx_data}, 32'h0);
    apb_read(32'h08, rd); chk("rst_mid_tx_empty", {31'd0, rd[0]}, 32'd1);
    apb_write(32'h0C, 32'h1);
    chk("rst_mid_not_queued", {31'd0, tx_valid}, 32'd0);

    // Random traffic against the model
    do_reset();
    rand_side = 1;
    for (int n = 0; n < 300; n++) begin
      int pick;
      logic [31:0] a;
      pick = $urandom_range(0, 9);
      a = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      case (pick)
        0, 1, 2: apb_write({a[31:5], 3'd0, a[1:0]}, $urandom);
        3, 4, 5: apb_read({a[31:5], 3'd1, a[1:0]}, rd);
        6:       if ($urandom_range(0, 1) == 1) apb_write(32'h08, $urandom);
                 else apb_read(32'h08, rd);
        7:       apb_write(32'h0C, $urandom);
        8:       if ($urandom_range(0, 1) == 1) apb_write(32'h10, $urandom);
                 else apb_read(32'h10, rd);
        default: if ($urandom_range(0, 1) == 1) apb_write(a, $urandom);
                 else apb_read(a, rd);
      endcase
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
    end
    rand_side = 0;
    tx_ready = 1'b0; rx_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
